spi_segment_frontend: RTL and testbench

Command front-end between the SPI secondary and the segment FIFO. It decodes the host's byte stream per chip-select frame, assembles `RECORD_BYTES` payload bytes into whole records, and pushes each record atomically downstream. It reports free FIFO slots and sticky error flags back on MISO. Compared with the single-command receive path, it adds parametrised record width, atomic record commit, discard of partial records, overflow detection, and status, clear and flush commands.

---
 rtl/spi_segment_frontend.sv | 142 ++++++++++++++
 tb/tb_spi_segment_frontend.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_segment_frontend.sv
// spi_segment_frontend: decodes the SPI host byte stream per frame,
// assembles fixed-size records and pushes them atomically downstream.
`timescale 1ns/1ps
module spi_segment_frontend #(
    parameter int RECORD_BYTES = 4,
    parameter int COUNT_BITS   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      spi_cs,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    output logic [7:0]                tx_data,
    input  logic [7:0]                free_slots,
    input  logic                      rec_ready,
    output logic                      rec_valid,
    output logic [8*RECORD_BYTES-1:0] rec_data,
    output logic                      fifo_flush,
    output logic [7:0]                flags,
    output logic [COUNT_BITS-1:0]     rec_count
);

    localparam int RW = 8 * RECORD_BYTES;
    localparam int IW = (RECORD_BYTES > 1) ? $clog2(RECORD_BYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(RECORD_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WRITE,
        S_STATUS,
        S_DRAIN
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] idx;
    logic [RW-1:0] asm_buf;
    logic [RW-1:0] asm_nxt;
    logic [2:0]    flg;
    logic [2:0]    flg_set;
    logic [2:0]    flg_nxt;
    logic          flg_clr;
    logic          push;
    logic          flush;
    logic          wr_start;
    logic          wr_byte;
    logic [7:0]    tx_nxt;

    // Command decode, write assembly and flag updates for this cycle
    always_comb begin
        state_nxt = state;
        flg_set   = 3'b000;
        flg_clr   = 1'b0;
        push      = 1'b0;
        flush     = 1'b0;
        wr_start  = 1'b0;
        wr_byte   = 1'b0;
        asm_nxt   = asm_buf;
        for (int i = 0; i < RECORD_BYTES; i++) begin
            if (idx == IW'(i)) asm_nxt[i*8 +: 8] = rx_data;
        end
        if (spi_cs) begin
            state_nxt = S_IDLE;
            if (state == S_WRITE && idx != '0) flg_set[1] = 1'b1;
        end else begin
            unique case (state)
                S_IDLE: state_nxt = S_CMD;
                S_CMD: begin
                    if (rx_valid) begin
                        unique case (rx_data)
                            8'h00: state_nxt = S_CMD;
                            8'h01: state_nxt = S_STATUS;
                            8'h02: begin
                                state_nxt = S_WRITE;
                                wr_start  = 1'b1;
                            end
                            8'h03: flg_clr = 1'b1;
                            8'h04: flush = 1'b1;
                            default: begin
                                flg_set[2] = 1'b1;
                                state_nxt  = S_DRAIN;
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    if (rx_valid) begin
                        wr_byte = 1'b1;
                        if (idx == LAST) begin
                            if (rec_ready) push = 1'b1;
                            else flg_set[0] = 1'b1;
                        end
                    end
                end
                S_STATUS: if (rx_valid) state_nxt = S_CMD;
                S_DRAIN: state_nxt = S_DRAIN;
                default: state_nxt = S_IDLE;
            endcase
        end
        flg_nxt = (flg_clr ? 3'b000 : flg) | flg_set;
        unique case (1'b1)
            state_nxt == S_STATUS: tx_nxt = {5'b0, flg_nxt};
            state_nxt == S_DRAIN:  tx_nxt = 8'h00;
            default:               tx_nxt = free_slots;
        endcase
    end

    // State, byte index, assembly buffer and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            idx        <= '0;
            asm_buf    <= '0;
            flg        <= 3'b000;
            tx_data    <= 8'h00;
            rec_valid  <= 1'b0;
            rec_data   <= '0;
            fifo_flush <= 1'b0;
            rec_count  <= '0;
        end else begin
            state      <= state_nxt;
            flg        <= flg_nxt;
            tx_data    <= tx_nxt;
            rec_valid  <= push;
            fifo_flush <= flush;
            if (spi_cs || wr_start) begin
                idx <= '0;
            end else if (wr_byte) begin
                asm_buf <= asm_nxt;
                idx     <= (idx == LAST) ? '0 : idx + IW'(1);
            end
            if (push) begin
                rec_data  <= asm_nxt;
                rec_count <= rec_count + COUNT_BITS'(1);
            end
        end
    end

    assign flags = {5'b00000, flg};

endmodule

// File: tb/tb_spi_segment_frontend.sv
// tb_spi_segment_frontend: directed table, corner sequences and
// randomized frames checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_spi_segment_frontend;

    localparam int RB = 4;
    localparam int CB = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          spi_cs;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [7:0]    tx_data;
    logic [7:0]    free_slots;
    logic          rec_ready;
    logic          rec_valid;
    logic [8*RB-1:0] rec_data;
    logic          fifo_flush;
    logic [7:0]    flags;
    logic [CB-1:0] rec_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spi_segment_frontend #(.RECORD_BYTES(RB), .COUNT_BITS(CB)) dut (
        .clk(clk), .rst_n(rst_n), .spi_cs(spi_cs),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
        .free_slots(free_slots), .rec_ready(rec_ready),
        .rec_valid(rec_valid), .rec_data(rec_data),
        .fifo_flush(fifo_flush), .flags(flags), .rec_count(rec_count)
    );

    typedef struct {
        bit          cs;
        bit          v;
        logic [7:0]  d;
        bit          rdy;
        logic [7:0]  fs;
        logic [7:0]  tx;
        bit          rv;
        logic [31:0] rec;
        logic [7:0]  fl;
        logic [3:0]  cnt;
        bit          ff;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit cs, bit v, logic [7:0] d, bit rdy,
                                logic [7:0] fs, logic [7:0] tx, bit rv,
                                logic [31:0] rec, logic [7:0] fl,
                                logic [3:0] cnt, bit ff);
        vec_t e;
        e.cs = cs; e.v = v; e.d = d; e.rdy = rdy; e.fs = fs;
        e.tx = tx; e.rv = rv; e.rec = rec; e.fl = fl;
        e.cnt = cnt; e.ff = ff;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Apply inputs at a falling edge and let one rising edge consume them.
    task automatic drive(input bit cs, input bit v, input logic [7:0] d,
                         input bit rdy, input logic [7:0] fs);
        spi_cs = cs; rx_valid = v; rx_data = d;
        rec_ready = rdy; free_slots = fs;
        @(negedge clk);
    endtask

    task automatic gap();
        rx_valid = 1'b0;
        @(negedge clk);
        chk("gap_rec_valid", rec_valid, 0);
        chk("gap_fifo_flush", fifo_flush, 0);
    endtask

    // Reference model: frame mode plus a queue of pending payload bytes.
    localparam int M_IDLE = 0, M_CMD = 1, M_WR = 2, M_STAT = 3, M_DRAIN = 4;
    int            m_mode;
    logic [7:0]    m_part[$];
    logic [2:0]    m_flags;
    logic [CB-1:0] m_count;

    task automatic model_reset();
        m_mode = M_IDLE;
        m_part.delete();
        m_flags = 3'b000;
        m_count = '0;
    endtask

    task automatic rstep(input bit cs, input bit v, input logic [7:0] d,
                         input bit rdy, input logic [7:0] fs);
        bit          erv = 1'b0;
        bit          eff = 1'b0;
        logic [31:0] erec = '0;
        logic [7:0]  etx;
        drive(cs, v, d, rdy, fs);
        if (cs) begin
            if (m_mode == M_WR && m_part.size() != 0) m_flags[1] = 1'b1;
            m_part.delete();
            m_mode = M_IDLE;
        end else if (m_mode == M_IDLE) begin
            m_mode = M_CMD;
        end else if (v && m_mode == M_CMD) begin
            if (d == 8'h01) m_mode = M_STAT;
            else if (d == 8'h02) begin m_mode = M_WR; m_part.delete(); end
            else if (d == 8'h03) m_flags = 3'b000;
            else if (d == 8'h04) eff = 1'b1;
            else if (d != 8'h00) begin m_flags[2] = 1'b1; m_mode = M_DRAIN; end
        end else if (v && m_mode == M_WR) begin
            m_part.push_back(d);
            if (m_part.size() == RB) begin
                if (rdy) begin
                    erv = 1'b1;
                    for (int i = 0; i < RB; i++) erec[8*i +: 8] = m_part[i];
                    m_count = m_count + 1'b1;
                end else begin
                    m_flags[0] = 1'b1;
                end
                m_part.delete();
            end
        end else if (v && m_mode == M_STAT) begin
            m_mode = M_CMD;
        end
        if (m_mode == M_STAT) etx = {5'b0, m_flags};
        else if (m_mode == M_DRAIN) etx = 8'h00;
        else etx = fs;
        chk("r_tx", tx_data, etx);
        chk("r_rec_valid", rec_valid, erv);
        if (erv) chk("r_rec_data", rec_data, erec);
        chk("r_flags", flags, {5'b0, m_flags});
        chk("r_count", rec_count, m_count);
        chk("r_flush", fifo_flush, eff);
    endtask

    function automatic logic [7:0] pick_byte();
        int r;
        r = $urandom_range(0, 15);
        if (m_mode != M_CMD) return 8'($urandom);
        if (r < 2) return 8'h00;
        if (r < 4) return 8'h01;
        if (r < 10) return 8'h02;
        if (r < 11) return 8'h03;
        if (r < 13) return 8'h04;
        return 8'($urandom_range(5, 255));
    endfunction

    initial begin
        rst_n = 1'b1; spi_cs = 1'b1; rx_valid = 1'b0;
        rx_data = 8'h00; rec_ready = 1'b1; free_slots = 8'h03;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_tx", tx_data, 8'h00);
        chk("rst_rec_valid", rec_valid, 0);
        chk("rst_rec_data", rec_data, 0);
        chk("rst_flush", fifo_flush, 0);
        chk("rst_flags", flags, 8'h00);
        chk("rst_count", rec_count, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // cs,v,d,rdy,fs | tx,rv,rec,flags,count,flush
        tbl.push_back(mk(1,0,8'h00,1,3, 3,0,0,0,0,0));
        tbl.push_back(mk(0,0,8'h00,1,3, 3,0,0,0,0,0));
        tbl.push_back(mk(0,1,8'h02,1,3, 3,0,0,0,0,0));
        tbl.push_back(mk(0,1,8'h11,1,3, 3,0,0,0,0,0));
        tbl.push_back(mk(0,1,8'h12,1,3, 3,0,0,0,0,0));
        tbl.push_back(mk(0,1,8'h13,1,3, 3,0,0,0,0,0));
        tbl.push_back(mk(0,1,8'h14,1,3, 3,1,32'h14131211,0,1,0));
        tbl.push_back(mk(0,1,8'h15,1,3, 3,0,0,0,1,0));
        tbl.push_back(mk(0,1,8'h16,1,3, 3,0,0,0,1,0));
        tbl.push_back(mk(0,1,8'h17,1,3, 3,0,0,0,1,0));
        tbl.push_back(mk(0,1,8'h18,1,3, 3,1,32'h18171615,0,2,0));
        tbl.push_back(mk(1,0,8'h00,1,3, 3,0,0,0,2,0));
        tbl.push_back(mk(0,0,8'h00,1,3, 3,0,0,0,2,0));
        tbl.push_back(mk(0,1,8'h7F,1,3, 0,0,0,4,2,0));
        tbl.push_back(mk(0,1,8'h02,1,3, 0,0,0,4,2,0));
        tbl.push_back(mk(0,1,8'hAA,1,3, 0,0,0,4,2,0));
        tbl.push_back(mk(1,0,8'h00,1,3, 3,0,0,4,2,0));
        tbl.push_back(mk(0,0,8'h00,1,3, 3,0,0,4,2,0));
        tbl.push_back(mk(0,1,8'h01,1,3, 4,0,0,4,2,0));
        tbl.push_back(mk(0,1,8'h00,1,3, 3,0,0,4,2,0));
        tbl.push_back(mk(0,1,8'h00,1,9, 9,0,0,4,2,0));
        tbl.push_back(mk(0,1,8'h04,1,9, 9,0,0,4,2,1));
        tbl.push_back(mk(0,1,8'h03,1,9, 9,0,0,0,2,0));
        tbl.push_back(mk(0,1,8'h02,1,9, 9,0,0,0,2,0));
        tbl.push_back(mk(0,1,8'hA1,1,9, 9,0,0,0,2,0));
        tbl.push_back(mk(0,1,8'hA2,1,9, 9,0,0,0,2,0));
        tbl.push_back(mk(0,1,8'hA3,1,9, 9,0,0,0,2,0));
        tbl.push_back(mk(0,1,8'hA4,0,9, 9,0,0,1,2,0));
        tbl.push_back(mk(0,1,8'hB1,1,9, 9,0,0,1,2,0));
        tbl.push_back(mk(0,1,8'hB2,1,9, 9,0,0,1,2,0));
        tbl.push_back(mk(0,1,8'hB3,1,9, 9,0,0,1,2,0));
        tbl.push_back(mk(0,1,8'hB4,1,9, 9,1,32'hB4B3B2B1,1,3,0));
        tbl.push_back(mk(0,1,8'hC1,1,9, 9,0,0,1,3,0));
        tbl.push_back(mk(0,1,8'hC2,1,9, 9,0,0,1,3,0));
        tbl.push_back(mk(0,1,8'hC3,1,9, 9,0,0,1,3,0));
        tbl.push_back(mk(1,0,8'h00,1,9, 9,0,0,3,3,0));
        tbl.push_back(mk(0,0,8'h00,1,9, 9,0,0,3,3,0));
        tbl.push_back(mk(0,1,8'h02,1,9, 9,0,0,3,3,0));
        tbl.push_back(mk(0,1,8'hD1,1,9, 9,0,0,3,3,0));
        tbl.push_back(mk(0,1,8'hD2,1,9, 9,0,0,3,3,0));
        tbl.push_back(mk(0,1,8'hD3,1,9, 9,0,0,3,3,0));
        tbl.push_back(mk(0,1,8'hD4,1,9, 9,1,32'hD4D3D2D1,3,4,0));
        tbl.push_back(mk(1,0,8'h00,1,9, 9,0,0,3,4,0));

        @(negedge clk);
        foreach (tbl[i]) begin
            drive(tbl[i].cs, tbl[i].v, tbl[i].d, tbl[i].rdy, tbl[i].fs);
            chk($sformatf("t%0d_tx", i), tx_data, tbl[i].tx);
            chk($sformatf("t%0d_rv", i), rec_valid, tbl[i].rv);
            if (tbl[i].rv) chk($sformatf("t%0d_rec", i), rec_data, tbl[i].rec);
            chk($sformatf("t%0d_flags", i), flags, tbl[i].fl);
            chk($sformatf("t%0d_count", i), rec_count, tbl[i].cnt);
            chk($sformatf("t%0d_flush", i), fifo_flush, tbl[i].ff);
            gap();
        end

        // Reset in the middle of a record, then a clean record
        drive(0, 0, 8'h00, 1, 9);
        drive(0, 1, 8'h02, 1, 9); gap();
        drive(0, 1, 8'hE1, 1, 9); gap();
        drive(0, 1, 8'hE2, 1, 9); gap();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", tx_data, 8'h00);
        chk("mid_rst_rec_valid", rec_valid, 0);
        chk("mid_rst_rec_data", rec_data, 0);
        chk("mid_rst_flush", fifo_flush, 0);
        chk("mid_rst_flags", flags, 8'h00);
        chk("mid_rst_count", rec_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 8'h00, 1, 9);
        drive(0, 1, 8'h02, 1, 9); gap();
        drive(0, 1, 8'hF1, 1, 9); gap();
        drive(0, 1, 8'hF2, 1, 9); gap();
        drive(0, 1, 8'hF3, 1, 9); gap();
        drive(0, 1, 8'hF4, 1, 9);
        chk("post_rst_rv", rec_valid, 1);
        chk("post_rst_rec", rec_data, 32'hF4F3F2F1);
        chk("post_rst_count", rec_count, 1);
        chk("post_rst_flags", flags, 8'h00);
        gap();

        // Randomized frames against the reference model
        drive(1, 0, 8'h00, 1, 9);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int f = 0; f < 300; f++) begin
            int len;
            len = $urandom_range(1, 14);
            rstep(0, 0, 8'h00, 1'($urandom), 8'($urandom));
            for (int k = 0; k < len; k++) begin
                logic [7:0] fs;
                fs = 8'($urandom);
                rstep(0, 1, pick_byte(), ($urandom_range(0, 3) != 0), fs);
                rstep(0, 0, 8'($urandom), 1'($urandom), fs);
                if ($urandom_range(0, 3) == 0)
                    rstep(0, 0, 8'h00, 1'($urandom), fs);
            end
            rstep(1, 0, 8'h00, 1'($urandom), 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
